midi_note_tracker: RTL and testbench

//  Monophonic MIDI channel-voice parser placed directly upstream of note2dds_1st_gen.

---
 rtl/midi_note_tracker.sv | 154 +++++++++++++++
 tb/tb_midi_note_tracker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/midi_note_tracker.sv
// Monophonic MIDI voice parser: decodes Note On/Off and All Notes Off for one
// channel and holds the last-note-priority pitch, velocity and gate for note2dds.
module midi_note_tracker #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic [7:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       GATE,
  output logic       NOTE_STB
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_D1   = 2'd1;
  localparam logic [1:0] ST_D2   = 2'd2;

  localparam logic [3:0] TYPE_NOTE_OFF = 4'h8;
  localparam logic [3:0] TYPE_NOTE_ON  = 4'h9;
  localparam logic [3:0] TYPE_CC       = 4'hB;
  localparam logic [3:0] TYPE_PROG     = 4'hC;
  localparam logic [3:0] TYPE_CHAN_AT  = 4'hD;
  localparam logic [6:0] CC_ALL_OFF    = 7'h7B;

  logic [1:0] state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       stb_q, stb_d;

  logic       is_realtime;
  logic       is_system;
  logic       is_status;
  logic [6:0] data;
  logic       one_byte_msg;
  logic       ours;
  logic       done;
  logic [6:0] kk;
  logic [6:0] vv;
  logic       release_hit;

  assign is_realtime  = (BYTE_IN[7:3] == 5'b11111);
  assign is_system    = (BYTE_IN[7:4] == 4'hF) && !BYTE_IN[3];
  assign is_status    = BYTE_IN[7];
  assign data         = BYTE_IN[6:0];
  assign one_byte_msg = (status_q[7:4] == TYPE_PROG) || (status_q[7:4] == TYPE_CHAN_AT);
  assign ours         = OMNI || (status_q[3:0] == CHANNEL);
  assign release_hit  = gate_q && (kk == note_q);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    note_d   = note_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    stb_d    = 1'b0;
    done     = 1'b0;
    kk       = 7'd0;
    vv       = 7'd0;

    // Realtime bytes fall through untouched so they can interleave mid-message.
    if (BYTE_VALID && !is_realtime) begin
      if (is_system) begin
        state_d  = ST_IDLE;
        status_d = 8'h00;
      end else if (is_status) begin
        status_d = BYTE_IN;
        state_d  = ST_D1;
      end else begin
        case (state_q)
          ST_D1: begin
            d1_d = data;
            if (one_byte_msg) begin
              done = 1'b1;
              kk   = data;
            end else begin
              state_d = ST_D2;
            end
          end
          ST_D2: begin
            done    = 1'b1;
            kk      = d1_q;
            vv      = data;
            state_d = ST_D1;
          end
          default: begin
          end
        endcase
      end
    end

    if (done && ours) begin
      case (status_q[7:4])
        TYPE_NOTE_ON: begin
          if (vv != 7'd0) begin
            note_d = kk;
            vel_d  = vv;
            gate_d = 1'b1;
            stb_d  = 1'b1;
          end else if (release_hit) begin
            gate_d = 1'b0;
            stb_d  = 1'b1;
          end
        end
        TYPE_NOTE_OFF: begin
          if (release_hit) begin
            gate_d = 1'b0;
            stb_d  = 1'b1;
          end
        end
        TYPE_CC: begin
          if ((kk == CC_ALL_OFF) && gate_q) begin
            gate_d = 1'b0;
            stb_d  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      gate_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      stb_q    <= stb_d;
    end
  end

  assign NOTE     = {1'b0, note_q};
  assign VELOCITY = vel_q;
  assign GATE     = gate_q;
  assign NOTE_STB = stb_q;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed bench for midi_note_tracker with hand-computed expectations.
module tb_midi_note_tracker;

  logic       CLK;
  logic       RESET;
  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic [7:0] NOTE;
  logic [6:0] VELOCITY;
  logic       GATE;
  logic       NOTE_STB;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  int cnt0;

  midi_note_tracker #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BYTE_IN   (BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .NOTE      (NOTE),
    .VELOCITY  (VELOCITY),
    .GATE      (GATE),
    .NOTE_STB  (NOTE_STB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (NOTE_STB) stb_cnt <= stb_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge CLK);
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      BYTE_VALID = 1'b0;
      BYTE_IN    = 8'h00;
    end
  endtask

  task automatic mark();
    #1 cnt0 = stb_cnt;
  endtask

  initial begin
    RESET      = 1'b0;
    BYTE_IN    = 8'h00;
    BYTE_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_note", NOTE, 8'h00);
    check("rst_vel", VELOCITY, 7'h00);
    check("rst_gate", GATE, 1'b0);
    check("rst_stb", NOTE_STB, 1'b0);
    RESET = 1'b1;
    idle(1);

    // Test 1: basic note on, strobe one clock after the last byte
    mark();
    put(8'h90); put(8'h3C); put(8'h64); idle(1);
    check("t1_stb_now", NOTE_STB, 1'b1);
    check("t1_note", NOTE, 8'h3C);
    check("t1_vel", VELOCITY, 7'h64);
    check("t1_gate", GATE, 1'b1);
    idle(1);
    check("t1_stb_gone", NOTE_STB, 1'b0);
    check("t1_pulses", stb_cnt - cnt0, 1);

    // Test 2: running status and note-off matching
    mark();
    put(8'h90); put(8'h3C); put(8'h64); put(8'h40); put(8'h50); idle(2);
    check("t2_pulses", stb_cnt - cnt0, 2);
    check("t2_note", NOTE, 8'h40);
    check("t2_vel", VELOCITY, 7'h50);
    check("t2_gate", GATE, 1'b1);
    mark();
    put(8'h3C); put(8'h00); idle(2);
    check("t2_off_miss_pulses", stb_cnt - cnt0, 0);
    check("t2_off_miss_gate", GATE, 1'b1);
    mark();
    put(8'h40); put(8'h00); idle(2);
    check("t2_off_pulses", stb_cnt - cnt0, 1);
    check("t2_off_gate", GATE, 1'b0);
    check("t2_off_note", NOTE, 8'h40);
    check("t2_off_vel", VELOCITY, 7'h50);

    // Test 3: realtime bytes interleaved mid-message
    mark();
    put(8'h90); put(8'hF8); put(8'h45); put(8'hFE); put(8'h7F); idle(2);
    check("t3_pulses", stb_cnt - cnt0, 1);
    check("t3_note", NOTE, 8'h45);
    check("t3_vel", VELOCITY, 7'h7F);
    check("t3_gate", GATE, 1'b1);
    // Retrigger of the held note via running status
    mark();
    put(8'h45); put(8'h70); idle(2);
    check("t3_retrig_pulses", stb_cnt - cnt0, 1);
    check("t3_retrig_vel", VELOCITY, 7'h70);

    // Test 4: channel filter, then All Notes Off
    mark();
    put(8'h91); put(8'h30); put(8'h40); idle(2);
    check("t4_filt_pulses", stb_cnt - cnt0, 0);
    check("t4_filt_note", NOTE, 8'h45);
    check("t4_filt_gate", GATE, 1'b1);
    mark();
    put(8'hB0); put(8'h7B); put(8'h00); idle(2);
    check("t4_ano_pulses", stb_cnt - cnt0, 1);
    check("t4_ano_gate", GATE, 1'b0);
    check("t4_ano_note", NOTE, 8'h45);

    // Test 5: aborted message, note-off with gate low, SysEx clears running status
    mark();
    put(8'h90); put(8'h3C); put(8'h80); put(8'h3C); put(8'h40); idle(2);
    check("t5_abort_pulses", stb_cnt - cnt0, 0);
    check("t5_abort_gate", GATE, 1'b0);
    check("t5_abort_note", NOTE, 8'h45);
    mark();
    put(8'h90); put(8'h30); put(8'h20); idle(2);
    check("t5_pre_note", NOTE, 8'h30);
    mark();
    put(8'hF0); put(8'h3C); put(8'h64); put(8'h50); put(8'h60); idle(2);
    check("t5_sysex_pulses", stb_cnt - cnt0, 0);
    check("t5_sysex_note", NOTE, 8'h30);
    check("t5_sysex_vel", VELOCITY, 7'h20);

    // Test 6: asynchronous reset mid-message, then orphan data ignored
    put(8'h90); put(8'h3C); put(8'h64); idle(1);
    check("t6_pre_gate", GATE, 1'b1);
    put(8'h90); put(8'h48); idle(1);
    #2 RESET = 1'b0;
    #1;
    check("t6_rst_note", NOTE, 8'h00);
    check("t6_rst_vel", VELOCITY, 7'h00);
    check("t6_rst_gate", GATE, 1'b0);
    check("t6_rst_stb", NOTE_STB, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    mark();
    put(8'h48); put(8'h64); idle(2);
    check("t6_idle_pulses", stb_cnt - cnt0, 0);
    check("t6_idle_note", NOTE, 8'h00);
    check("t6_idle_gate", GATE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
